uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Byte-stream bootloader directly downstream of the UART receiver.
- Pops received bytes through the receiver's re/full handshake and parses a framed load command: sync byte, base address, word count, payload.
- Packs the payload little-endian into 32-bit words and writes them to the memory bus. This lets the host load program images into RAM before releasing the CPU.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort (must be >= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  byte from the UART receiver (valid while rx_full=1)
- rx_full  in  1  receiver holds an unread byte
- rx_re  out  1  pop strobe to the receiver; combinational
- mem_addr  out  32  byte address of the current word write
- mem_wdata  out  32  word to write
- mem_we  out  1  write request; held until accepted
- mem_ready  in  1  memory accepts the write on a clock edge where mem_we=1 and mem_ready=1
- busy  out  1  high while any frame is in progress (any state other than IDLE)
- done  out  1  one-cycle pulse when a frame completes
- error  out  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-frame discards all partial data; any pending mem_we drops on the next edge.
- Byte handshake:
  - rx_re = rx_full AND (state in IDLE, ADDR, LEN, DATA).
  - A byte is consumed on every edge where rx_re=1; rx_data is captured on that same edge.
  - rx_re is never asserted in WRITE or DONE. The receiver holds its byte until the loader returns to a consuming state.
- States:
  - IDLE: consume a byte. If it equals SYNC_BYTE, go to ADDR with byte index 0; any other byte is discarded silently.
  - ADDR: consume 4 bytes, LSB first, into the base address. After the 4th byte, go to LEN.
  - LEN: consume 2 bytes, LSB first, into a 16-bit word count.
    - After the 2nd byte: if count == 0, go to DONE; otherwise go to DATA.
    - mem_addr takes the base address on that same edge.
  - DATA: consume 4 bytes, LSB first. Byte k goes to mem_wdata[8k+7:8k]. After the 4th byte, go to WRITE with mem_we=1 on the next cycle.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ready=1.
    - On the accepting edge: mem_we goes to 0, mem_addr increments by 4 (wraps modulo 2^32), and the remaining count decrements.
    - If the remaining count becomes 0, go to DONE; else go to DATA.
  - DONE: done=1 for exactly one cycle, then go to IDLE. mem_addr retains the last value + 4.
- Throughput: with mem_ready tied high, a write costs 1 cycle beyond the 4th byte's arrival.
- Timeout:
  - A 32-bit counter runs in ADDR, LEN and DATA. It clears on every consumed byte and on entry to those states, and holds in WRITE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte consumed that cycle: go to IDLE, pulse error for 1 cycle, discard the partial word (no write issued).
  - A byte arriving on the terminal cycle takes priority over the timeout.
- Simultaneous events:
  - rst overrides everything.
  - mem_ready asserted while mem_we=0 is ignored.
  - rx_full during WRITE is ignored until WRITE exits.
- Width rules: word count is a 16-bit unsigned value. The maximum frame is 65535 words; the address wraps silently past 32'hFFFF_FFFC.
- busy = (state != IDLE). done and error are never high in the same cycle.

Test Plan:
1. Bytes A5, 00 10 00 00, 02 00, 11 22 33 44, 55 66 77 88 with mem_ready=1 -> exactly two writes: (0x00001000, 0x44332211) then (0x00001004, 0x88776655); one done pulse after the second write; busy returns to 0; no error.
2. Bytes 00, 7F, A5, 00 00 00 00, 00 00 -> the first two bytes are consumed and dropped; no mem_we at any point; one done pulse; rx_re pulses once per byte.
3. Same frame as test 1 with mem_ready held low for 5 cycles on each write, and the next byte already waiting (rx_full=1) during WRITE -> mem_we, mem_addr and mem_wdata stable for 6 cycles each; rx_re=0 throughout WRITE; writes are correct.
4. TIMEOUT_CYCLES=16; send A5, 00 20 00 00, 01 00, AA BB then stop -> error pulses 16 cycles after BB; no mem_we; state returns to IDLE; a fresh frame afterwards completes normally.
5. Address FC FF FF FF with count 2 -> writes land at 0xFFFFFFFC then 0x00000000.
6. Assert rst for 1 cycle while mem_we=1 mid-frame -> all outputs 0 on the next cycle; the following valid frame loads correctly.

Source files
------------

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Brief    : UART byte-stream bootloader; parses sync/addr/len/payload frames
//            and writes little-endian 32-bit words to the memory bus.
// Revision : 1.0
// ============================================================================
module uart_loader #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_full,
   output logic        rx_re,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_LEN   = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_idx;
   logic [31:0] r_base;
   logic [15:0] r_count;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic        r_error;
   logic [31:0] r_timer;

   logic        w_rx_re;
   logic        w_counting;
   logic        w_timeout;
   logic        w_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_rx_re      = 1'b0;
      w_counting   = 1'b0;
      w_timeout    = 1'b0;
      w_accept     = 1'b0;
      w_next_state = r_state;

      w_counting = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_DATA);
      w_rx_re    = rx_full && (w_counting || (r_state == S_IDLE));
      // A byte arriving on the terminal cycle wins over the timeout.
      w_timeout  = w_counting && !w_rx_re && (r_timer == c_timeout_last);
      w_accept   = r_we && mem_ready;

      case (r_state)
         S_IDLE: begin
            if (w_rx_re && (rx_data == SYNC_BYTE)) begin
               w_next_state = S_ADDR;
            end
         end
         S_ADDR: begin
            if (w_timeout) begin
               w_next_state = S_IDLE;
            end else if (w_rx_re && (r_idx == 2'd3)) begin
               w_next_state = S_LEN;
            end
         end
         S_LEN: begin
            if (w_timeout) begin
               w_next_state = S_IDLE;
            end else if (w_rx_re && (r_idx == 2'd1)) begin
               w_next_state = ({rx_data, r_count[7:0]} == 16'd0) ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_timeout) begin
               w_next_state = S_IDLE;
            end else if (w_rx_re && (r_idx == 2'd3)) begin
               w_next_state = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_accept) begin
               w_next_state = (r_count == 16'd1) ? S_DONE : S_DATA;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= 2'd0;
         r_base  <= 32'd0;
         r_count <= 16'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_we    <= 1'b0;
         r_error <= 1'b0;
         r_timer <= 32'd0;
      end else begin
         r_error <= w_timeout;

         if (w_rx_re) begin
            case (r_state)
               S_IDLE: begin
                  r_idx <= 2'd0;
               end
               S_ADDR: begin
                  r_base[{r_idx, 3'b000} +: 8] <= rx_data;
                  r_idx <= r_idx + 2'd1;
               end
               S_LEN: begin
                  if (r_idx == 2'd0) begin
                     r_count[7:0] <= rx_data;
                     r_idx        <= 2'd1;
                  end else begin
                     r_count[15:8] <= rx_data;
                     r_addr        <= r_base;
                     r_idx         <= 2'd0;
                  end
               end
               S_DATA: begin
                  r_wdata[{r_idx, 3'b000} +: 8] <= rx_data;
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_we <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end

         // An aborted frame leaves any partial word unwritten.
         if (w_timeout) begin
            r_idx <= 2'd0;
         end

         if (w_accept) begin
            r_we    <= 1'b0;
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count - 16'd1;
         end

         // Idle timer holds while waiting on memory and restarts on re-entry to DATA.
         if (w_rx_re || w_timeout) begin
            r_timer <= 32'd0;
         end else if (r_state == S_WRITE) begin
            if (w_accept) begin
               r_timer <= 32'd0;
            end
         end else if (w_counting) begin
            r_timer <= r_timer + 32'd1;
         end else begin
            r_timer <= 32'd0;
         end
      end
   end

   assign rx_re     = w_rx_re;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = r_we;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Brief    : Directed self-checking bench for uart_loader.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_full = 1'b0;
   logic        rx_re;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        error;

   uart_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_full   (rx_full),
      .rx_re     (rx_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus monitor / memory responder, sampled on the falling edge.
   logic        slow = 1'b0;
   int          ncyc = 0;
   int          rx_cnt = 0, rx_we = 0, rx_last = 0;
   int          done_cnt = 0, err_cnt = 0, err_last = 0;
   int          we_cnt = 0, wcyc = 0, unstable = 0;
   logic [31:0] a0, d0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wl[$];

   always @(negedge clk) begin
      ncyc++;
      if (rx_re) begin
         rx_cnt++;
         rx_last = ncyc;
         if (mem_we) rx_we++;
      end
      if (done) done_cnt++;
      if (error) begin
         err_cnt++;
         err_last = ncyc;
      end
      if (mem_we && !rst) begin
         we_cnt++;
         if (wcyc == 0) begin
            a0 = mem_addr;
            d0 = mem_wdata;
         end else if (mem_addr !== a0 || mem_wdata !== d0) begin
            unstable++;
         end
         wcyc++;
         mem_ready = !slow || (wcyc >= 6);
         if (mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wl.push_back(wcyc);
            wcyc = 0;
         end
      end else begin
         wcyc = 0;
         mem_ready = !slow;
      end
   end

   int stalls = 0;

   // Entered just after a rising edge; returns just after the consuming edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         rx_full = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      rx_data = b;
      rx_full = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (rx_re) break;
         n++;
         if (n > 100) begin
            stalls++;
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_full = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] addr, input logic [7:0] pay[$]);
      logic [15:0] words;
      words = 16'(pay.size() / 4);
      send_byte(8'hA5, 0);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 0);
      send_byte(words[7:0], 0);
      send_byte(words[15:8], 0);
      for (int i = 0; i < pay.size(); i++) send_byte(pay[i], 0);
   endtask

   task automatic wait_done(input int start);
      int n;
      n = 0;
      while (done_cnt == start && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   int s_rx, s_done, s_err, s_we, s_w, s_rxwe, s_uns;
   logic [7:0] pay[$];

   task automatic snap();
      s_rx = rx_cnt; s_done = done_cnt; s_err = err_cnt;
      s_we = we_cnt; s_w = wa.size(); s_rxwe = rx_we; s_uns = unstable;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done_err", {30'd0, done, error}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rx_re", {31'd0, rx_re}, 32'd0);
      @(posedge clk);
      #1;

      // Test 1: two words, memory always ready
      snap();
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_frame(32'h0000_1000, pay);
      wait_done(s_done);
      check("t1_nwrites", wa.size() - s_w, 32'd2);
      check("t1_addr0", wa[s_w], 32'h0000_1000);
      check("t1_data0", wd[s_w], 32'h4433_2211);
      check("t1_addr1", wa[s_w+1], 32'h0000_1004);
      check("t1_data1", wd[s_w+1], 32'h8877_6655);
      check("t1_we_len", wl[s_w], 32'd1);
      check("t1_done", done_cnt - s_done, 32'd1);
      check("t1_err", err_cnt - s_err, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd0);
      check("t1_rx_pulses", rx_cnt - s_rx, 32'd15);
      check("t1_final_addr", mem_addr, 32'h0000_1008);

      // Test 2: junk bytes then an empty frame
      snap();
      send_byte(8'h00, 0);
      send_byte(8'h7F, 0);
      pay = {};
      send_frame(32'h0000_0000, pay);
      wait_done(s_done);
      check("t2_rx_pulses", rx_cnt - s_rx, 32'd9);
      check("t2_we_cycles", we_cnt - s_we, 32'd0);
      check("t2_done", done_cnt - s_done, 32'd1);
      check("t2_busy", {31'd0, busy}, 32'd0);

      // Test 3: memory stalls 5 cycles per write, next byte waiting
      slow = 1'b1;
      snap();
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_frame(32'h0000_1000, pay);
      wait_done(s_done);
      slow = 1'b0;
      check("t3_nwrites", wa.size() - s_w, 32'd2);
      check("t3_addr0", wa[s_w], 32'h0000_1000);
      check("t3_data0", wd[s_w], 32'h4433_2211);
      check("t3_addr1", wa[s_w+1], 32'h0000_1004);
      check("t3_data1", wd[s_w+1], 32'h8877_6655);
      check("t3_we_len0", wl[s_w], 32'd6);
      check("t3_we_len1", wl[s_w+1], 32'd6);
      check("t3_stable", unstable - s_uns, 32'd0);
      check("t3_rx_in_write", rx_we - s_rxwe, 32'd0);
      check("t3_done", done_cnt - s_done, 32'd1);

      // Test 4: timeout mid-word, then a fresh frame with a terminal-cycle byte
      snap();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      n = 0;
      while (err_cnt == s_err && n < 60) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("t4_err", err_cnt - s_err, 32'd1);
      // BB is seen on rx_re one negedge before its edge; error 16 edges later.
      check("t4_err_delay", err_last - rx_last, 32'd17);
      check("t4_we_cycles", we_cnt - s_we, 32'd0);
      check("t4_done", done_cnt - s_done, 32'd0);
      check("t4_busy", {31'd0, busy}, 32'd0);
      snap();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 15);
      send_byte(8'h03, 0); send_byte(8'h04, 0);
      wait_done(s_done);
      check("t4b_err", err_cnt - s_err, 32'd0);
      check("t4b_nwrites", wa.size() - s_w, 32'd1);
      check("t4b_addr", wa[s_w], 32'h0000_3000);
      check("t4b_data", wd[s_w], 32'h0403_0201);

      // Test 5: address wrap
      snap();
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_frame(32'hFFFF_FFFC, pay);
      wait_done(s_done);
      check("t5_nwrites", wa.size() - s_w, 32'd2);
      check("t5_addr0", wa[s_w], 32'hFFFF_FFFC);
      check("t5_data0", wd[s_w], 32'h0403_0201);
      check("t5_addr1", wa[s_w+1], 32'h0000_0000);
      check("t5_data1", wd[s_w+1], 32'h0807_0605);
      check("t5_final_addr", mem_addr, 32'h0000_0004);

      // Test 6: reset while a write is pending
      slow = 1'b1;
      snap();
      pay = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(32'h0000_4000, pay);
      n = 0;
      forever begin
         @(negedge clk);
         if (mem_we || n > 20) break;
         n++;
      end
      check("t6_we_seen", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_we", {31'd0, mem_we}, 32'd0);
      check("t6_rst_addr", mem_addr, 32'd0);
      check("t6_rst_wdata", mem_wdata, 32'd0);
      check("t6_rst_flags", {29'd0, busy, done, error}, 32'd0);
      rst = 1'b0;
      slow = 1'b0;
      @(posedge clk);
      #1;
      check("t6_no_write", wa.size() - s_w, 32'd0);
      snap();
      pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame(32'h0000_5000, pay);
      wait_done(s_done);
      check("t6_nwrites", wa.size() - s_w, 32'd1);
      check("t6_addr", wa[s_w], 32'h0000_5000);
      check("t6_data", wd[s_w], 32'hEFBE_ADDE);
      check("t6_done", done_cnt - s_done, 32'd1);

      check("rx_stalls", stalls, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
